// File: rtl/m68k_bus_pkg.sv
// Shared types for the 68010-style bus controller: FSM states, size encoding
// and the read-lane extraction helper.
package m68k_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        STROBE,
        WSTRB,
        WAIT,
        LATCH,
        END,
        GRANT,
        BUSFREE
    } bus_state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Byte reads come from D15..D8 on even addresses and D7..D0 on odd ones.
    function automatic logic [15:0] lane_rdata(input logic size, input logic a0,
                                               input logic [15:0] d);
        logic [15:0] r;
        if (size == SIZE_WORD) begin
            r = d;
        end else if (a0) begin
            r = {8'h00, d[7:0]};
        end else begin
            r = {8'h00, d[15:8]};
        end
        return r;
    endfunction

endpackage

// File: rtl/m68k_sync2.sv
// Two-flop synchronizer for the active-low asynchronous bus inputs; resets to
// the negated level so nothing looks asserted while coming out of reset.
module m68k_sync2 (
    input  logic clk,
    input  logic rst_b,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68010-style asynchronous bus cycle sequencer with BR/BG/BGACK arbitration.
// One outstanding core request at a time; strobes are decoded from state.
module m68k_bus_ctrl
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic        req_size,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_berr,
    output logic [22:0] address_bus,
    output logic        as_b,
    output logic        uds_b,
    output logic        lds_b,
    output logic        rw_b,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic        bus_oe,
    input  logic [15:0] data_in,
    input  logic        dtack_b,
    input  logic        berr_b,
    input  logic        br_b,
    input  logic        bgack_b,
    output logic        bg_b
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic dtack_sb, berr_sb, br_sb, bgack_sb;
    logic dtack_s, berr_s, br_s, bgack_s;

    m68k_sync2 u_sync_dtack (.clk(clk), .rst_b(rst_b), .d_i(dtack_b), .q_o(dtack_sb));
    m68k_sync2 u_sync_berr  (.clk(clk), .rst_b(rst_b), .d_i(berr_b),  .q_o(berr_sb));
    m68k_sync2 u_sync_br    (.clk(clk), .rst_b(rst_b), .d_i(br_b),    .q_o(br_sb));
    m68k_sync2 u_sync_bgack (.clk(clk), .rst_b(rst_b), .d_i(bgack_b), .q_o(bgack_sb));

    assign dtack_s = ~dtack_sb;
    assign berr_s  = ~berr_sb;
    assign br_s    = ~br_sb;
    assign bgack_s = ~bgack_sb;

    bus_state_t    state_q, state_d;
    logic [23:0]   addr_q;
    logic          rw_q;
    logic          size_q;
    logic [15:0]   wdata_q;
    logic [15:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

    logic hs;
    logic misalign;
    logic uds_sel, lds_sel;

    // rst_b gating keeps ready low while reset is held, not just after it.
    assign req_ready = rst_b && (state_q == IDLE) && !dtack_s && !berr_s && !br_s;
    assign hs        = req_valid && req_ready;
    assign misalign  = (req_size == SIZE_WORD) && req_addr[0];
    assign uds_sel   = (size_q == SIZE_WORD) || !addr_q[0];
    assign lds_sel   = (size_q == SIZE_WORD) || addr_q[0];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (br_s) begin
                    state_d = GRANT;
                end else if (hs) begin
                    state_d = misalign ? END : ADDR;
                end
            end
            ADDR:   state_d = STROBE;
            STROBE: state_d = rw_q ? WAIT : WSTRB;
            WSTRB:  state_d = WAIT;
            WAIT: begin
                if (berr_s) begin
                    state_d = END;
                end else if (dtack_s) begin
                    state_d = LATCH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = END;
                end
            end
            LATCH: state_d = END;
            END:   state_d = IDLE;
            GRANT: begin
                if (bgack_s) begin
                    state_d = BUSFREE;
                end else if (!br_s) begin
                    state_d = IDLE;
                end
            end
            BUSFREE: begin
                if (!bgack_s && !br_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        as_b      = 1'b1;
        uds_b     = 1'b1;
        lds_b     = 1'b1;
        rw_b      = 1'b1;
        data_oe   = 1'b0;
        bus_oe    = 1'b1;
        bg_b      = 1'b1;
        rsp_valid = 1'b0;
        rsp_berr  = 1'b0;
        unique case (state_q)
            ADDR: rw_b = rw_q;
            STROBE: begin
                rw_b    = rw_q;
                as_b    = 1'b0;
                uds_b   = !(rw_q && uds_sel);
                lds_b   = !(rw_q && lds_sel);
                data_oe = !rw_q;
            end
            WSTRB, WAIT, LATCH: begin
                rw_b    = rw_q;
                as_b    = 1'b0;
                uds_b   = !uds_sel;
                lds_b   = !lds_sel;
                data_oe = !rw_q;
            end
            END: begin
                rsp_valid = 1'b1;
                rsp_berr  = err_q;
            end
            GRANT:   bg_b   = 1'b0;
            BUSFREE: bus_oe = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            addr_q  <= '0;
            rw_q    <= 1'b1;
            size_q  <= SIZE_BYTE;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (hs) begin
            addr_q  <= req_addr;
            rw_q    <= req_rw;
            size_q  <= req_size;
            wdata_q <= (req_size == SIZE_BYTE) ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
            rdata_q <= '0;
            err_q   <= misalign;
        end else if (state_q == WAIT && state_d == END) begin
            err_q   <= 1'b1;
        end else if (state_q == LATCH && rw_q) begin
            rdata_q <= lane_rdata(size_q, addr_q[0], data_in);
        end
    end

    // Held at zero outside WAIT so every WAIT entry starts a fresh count.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (state_q != WAIT) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign address_bus = addr_q[23:1];
    assign data_out    = wdata_q;
    assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Scoreboard bench for m68k_bus_ctrl: the driver queues expected responses at
// handshake, a negedge monitor records bus activity and checks each response.
module tb_m68k_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid, req_ready, req_rw, req_size;
    logic [23:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_berr;
    logic [15:0] rsp_rdata;
    logic [22:0] address_bus;
    logic        as_b, uds_b, lds_b, rw_b;
    logic [15:0] data_out, data_in;
    logic        data_oe, bus_oe;
    logic        dtack_b, berr_b, br_b, bgack_b, bg_b;

    m68k_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_berr(rsp_berr),
        .address_bus(address_bus), .as_b(as_b), .uds_b(uds_b), .lds_b(lds_b),
        .rw_b(rw_b), .data_out(data_out), .data_oe(data_oe), .bus_oe(bus_oe),
        .data_in(data_in), .dtack_b(dtack_b), .berr_b(berr_b), .br_b(br_b),
        .bgack_b(bgack_b), .bg_b(bg_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        berr;
        int          hs_edge;
        int          lat;
        logic        as_s, uds_s, lds_s, wr_s;
        logic        chk_dout;
        logic [15:0] dout;
        logic [22:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;

    logic        seen_as, seen_uds, seen_lds, seen_wr;
    logic [15:0] seen_dout;
    logic [22:0] seen_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_rec();
        seen_as   = 1'b0;
        seen_uds  = 1'b0;
        seen_lds  = 1'b0;
        seen_wr   = 1'b0;
        seen_dout = '0;
        seen_addr = '0;
    endtask

    // Monitor: records strobe activity and checks each response against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_b) begin
            clear_rec();
        end else begin
            if (!as_b) begin
                seen_as   = 1'b1;
                seen_addr = address_bus;
                if (!rw_b) seen_wr = 1'b1;
                if (data_oe) seen_dout = data_out;
            end
            if (!uds_b) seen_uds = 1'b1;
            if (!lds_b) seen_lds = 1'b1;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
                    chk("rsp_berr", {31'd0, rsp_berr}, {31'd0, e.berr});
                    chk("rsp_latency", cyc + 1 - e.hs_edge, e.lat);
                    chk("as_seen", {31'd0, seen_as}, {31'd0, e.as_s});
                    chk("uds_seen", {31'd0, seen_uds}, {31'd0, e.uds_s});
                    chk("lds_seen", {31'd0, seen_lds}, {31'd0, e.lds_s});
                    chk("write_seen", {31'd0, seen_wr}, {31'd0, e.wr_s});
                    chk("end_strobes", {28'd0, as_b, uds_b, lds_b, data_oe}, 32'hE);
                    if (e.as_s) chk("address", {9'd0, seen_addr}, {9'd0, e.addr});
                    if (e.chk_dout) chk("data_out", {16'd0, seen_dout}, {16'd0, e.dout});
                end
                clear_rec();
            end
        end
    end

    task automatic do_req(input logic rw, input logic size, input logic [23:0] addr,
                          input logic [15:0] wdata, input logic [15:0] din,
                          input logic dt, input logic be,
                          input logic [15:0] x_rdata, input logic x_berr, input int x_lat,
                          input logic x_as, input logic x_uds, input logic x_lds);
        exp_t e;
        logic ok;
        @(negedge clk);
        req_rw    = rw;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        data_in   = din;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("handshake", {31'd0, ok}, 32'd1);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        e.rdata    = x_rdata;
        e.berr     = x_berr;
        e.hs_edge  = cyc + 1;
        e.lat      = x_lat;
        e.as_s     = x_as;
        e.uds_s    = x_uds;
        e.lds_s    = x_lds;
        e.wr_s     = !rw && x_as;
        e.chk_dout = !rw && x_as;
        e.dout     = (size == 1'b0) ? {wdata[7:0], wdata[7:0]} : wdata;
        e.addr     = addr[23:1];
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (dt) dtack_b = 1'b0;
        if (be) berr_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rsp_arrived", {31'd0, ok}, 32'd1);
        dtack_b = 1'b1;
        berr_b  = 1'b1;
    endtask

    initial begin
        rst_b = 1'b0;
        req_valid = 1'b0; req_rw = 1'b1; req_size = 1'b1;
        req_addr = '0; req_wdata = '0; data_in = '0;
        dtack_b = 1'b1; berr_b = 1'b1; br_b = 1'b1; bgack_b = 1'b1;
        clear_rec();

        #12;
        chk("rst_strobes", {27'd0, as_b, uds_b, lds_b, rw_b, bg_b}, 32'h1F);
        chk("rst_data_oe", {31'd0, data_oe}, 32'd0);
        chk("rst_bus_oe", {31'd0, bus_oe}, 32'd1);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_address", {9'd0, address_bus}, 32'd0);
        chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // rw size addr wdata din dt be | rdata berr lat as uds lds
        do_req(1, 1, 24'h001000, 16'h0000, 16'hBEEF, 1, 0, 16'hBEEF, 0, 5, 1, 1, 1);
        do_req(0, 0, 24'h001001, 16'h005A, 16'h0000, 1, 0, 16'h0000, 0, 6, 1, 0, 1);
        do_req(1, 1, 24'h000003, 16'h0000, 16'h1111, 0, 0, 16'h0000, 1, 1, 0, 0, 0);
        do_req(1, 1, 24'h002000, 16'h0000, 16'h2222, 0, 0, 16'h0000, 1, 11, 1, 1, 1);
        do_req(1, 1, 24'h003000, 16'h0000, 16'h1234, 1, 1, 16'h0000, 1, 4, 1, 1, 1);
        do_req(1, 0, 24'h004000, 16'h0000, 16'hA5C3, 1, 0, 16'h00A5, 0, 5, 1, 1, 0);
        do_req(1, 0, 24'h004001, 16'h0000, 16'hA5C3, 1, 0, 16'h00C3, 0, 5, 1, 0, 1);
        do_req(0, 1, 24'h005002, 16'hCAFE, 16'h0000, 1, 0, 16'h0000, 0, 6, 1, 1, 1);

        // Arbitration: request pending while another master takes the bus.
        @(negedge clk);
        br_b = 1'b0;
        repeat (4) @(negedge clk);
        chk("grant_bg", {31'd0, bg_b}, 32'd0);
        chk("grant_bus_oe", {31'd0, bus_oe}, 32'd1);
        req_rw = 1'b1; req_size = 1'b1; req_addr = 24'h006000; req_valid = 1'b1;
        @(negedge clk);
        chk("grant_ready", {31'd0, req_ready}, 32'd0);
        bgack_b = 1'b0;
        repeat (4) @(negedge clk);
        chk("busfree_bus_oe", {31'd0, bus_oe}, 32'd0);
        chk("busfree_bg", {31'd0, bg_b}, 32'd1);
        chk("busfree_ready", {31'd0, req_ready}, 32'd0);
        chk("busfree_as", {31'd0, as_b}, 32'd1);
        bgack_b = 1'b1;
        br_b    = 1'b1;
        do_req(1, 1, 24'h006000, 16'h0000, 16'h7E81, 1, 0, 16'h7E81, 0, 5, 1, 1, 1);

        // Reset asserted while the cycle is waiting for DTACK.
        @(negedge clk);
        req_rw = 1'b1; req_size = 1'b1; req_addr = 24'h00A000; req_valid = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        chk("rstwait_handshake", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstwait_as_before", {31'd0, as_b}, 32'd0);
        #2;
        rst_b = 1'b0;
        #1;
        chk("rstwait_strobes", {29'd0, as_b, uds_b, lds_b}, 32'h7);
        @(negedge clk);
        chk("rstwait_rsp", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (5) @(negedge clk);

        do_req(1, 1, 24'h007FFE, 16'h0000, 16'h0F0F, 1, 0, 16'h0F0F, 0, 5, 1, 1, 1);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
